// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register bank: sweep FSM states and address-width derivation.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } sweep_state_e;

  localparam int unsigned REGFILE_DATA_W = 32;

  function automatic int unsigned regfile_addr_w(input int unsigned num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_sweep_fsm.sv
// Init-sweep sequencer: on request, steps a write pointer across every register, then pulses done.
module regfile_sweep_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = regfile_addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              init_busy,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sweep_we  = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        sweep_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DONE: begin
        init_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sweep_addr = cnt_q;
  assign init_busy  = (state_q != IDLE);

endmodule

// File: rtl/reg_file_bank.sv
// Register bank: one write port, two registered read ports with write bypass, hardware init sweep.
// Optional REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module reg_file_bank
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W   = REGFILE_DATA_W,
  parameter int unsigned       NUM_REGS = 16,
  parameter int unsigned       ADDR_W   = regfile_addr_w(NUM_REGS),
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              init_req,
  output logic              init_busy,
  output logic              init_done
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              wr_err_q, wr_err_d;

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_addr_ok, rd_a_ok, rd_b_ok;
  logic              commit_we;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;

  regfile_sweep_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sweep (
    .clk        (clk),
    .rst        (clr),
    .init_req   (init_req),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .init_busy  (init_busy),
    .init_done  (init_done)
  );

  assign wr_addr_ok = ({1'b0, wr_addr} < REG_COUNT);
  assign rd_a_ok    = ({1'b0, rd_addr_a} < REG_COUNT) && !(R0_ZERO && rd_addr_a == '0);
  assign rd_b_ok    = ({1'b0, rd_addr_b} < REG_COUNT) && !(R0_ZERO && rd_addr_b == '0);

  // Sweep owns the write port; user writes only land while idle.
  always_comb begin
    commit_we   = 1'b0;
    commit_addr = wr_addr;
    commit_data = wr_data;
    if (sweep_we) begin
      commit_we   = 1'b1;
      commit_addr = sweep_addr;
      commit_data = INIT_VAL;
    end else if (wr_en && !init_busy && wr_addr_ok) begin
      commit_we = 1'b1;
    end
    if (R0_ZERO && commit_addr == '0) begin
      commit_we = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (commit_we) begin
      regs_d[commit_addr] = commit_data;
    end

    rd_data_a_d = '0;
    if (commit_we && commit_addr == rd_addr_a) begin
      rd_data_a_d = commit_data;
    end else if (rd_a_ok) begin
      rd_data_a_d = regs_q[rd_addr_a];
    end

    rd_data_b_d = '0;
    if (commit_we && commit_addr == rd_addr_b) begin
      rd_data_b_d = commit_data;
    end else if (rd_b_ok) begin
      rd_data_b_d = regs_q[rd_addr_b];
    end

    wr_err_d = wr_en && (init_busy || !wr_addr_ok);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      regs_q      <= '{default: '0};
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Bench for reg_file_bank: directed scenarios plus random traffic against a behavioural model.
module tb_reg_file_bank;

  localparam int          NREG = 12;
  localparam int          AW   = 4;
  localparam logic [31:0] INIT = 32'h5A5A_0F0F;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_err;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [31:0]   rd_data_a, rd_data_b;
  logic          init_req, init_busy, init_done;

  int n_pass = 0;
  int n_total = 0;

  reg_file_bank #(
    .DATA_W   (32),
    .NUM_REGS (NREG),
    .INIT_VAL (INIT)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .init_req  (init_req),
    .init_busy (init_busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Model: register contents as an array; sweep progress as cycles elapsed since the request
  // was accepted (1..NREG write index-1, NREG+1 is the done cycle, 0 means idle).
  logic [31:0] m_regs [NREG];
  int          m_phase;
  bit          m_valid = 1'b0;
  logic [31:0] exp_a, exp_b;
  logic        exp_err, exp_busy, exp_done;

  function automatic logic [31:0] model_read(input int a, input bit cw, input int ci,
                                             input logic [31:0] cv, input logic [31:0] stored);
    if (a >= NREG) return 32'h0;
    if (cw && ci == a) return cv;
    if (R0 && a == 0) return 32'h0;
    return stored;
  endfunction

  always @(posedge clk or posedge clr) begin
    int          idx, nxt;
    bit          cw;
    logic [31:0] cv;
    if (clr) begin
      for (int i = 0; i < NREG; i++) m_regs[i] <= 32'h0;
      m_phase  <= 0;
      exp_a    <= 32'h0;
      exp_b    <= 32'h0;
      exp_err  <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      m_valid  <= 1'b1;
    end else begin
      cw = 1'b0; idx = 0; cv = 32'h0;
      if (m_phase >= 1 && m_phase <= NREG) begin
        cw = 1'b1; idx = m_phase - 1; cv = INIT;
      end else if (m_phase == 0 && wr_en && int'(wr_addr) < NREG) begin
        cw = 1'b1; idx = int'(wr_addr); cv = wr_data;
      end
      if (R0 && idx == 0) cw = 1'b0;
      exp_err <= wr_en && (m_phase != 0 || int'(wr_addr) >= NREG);
      exp_a <= model_read(int'(rd_addr_a), cw, idx, cv,
                          (int'(rd_addr_a) < NREG) ? m_regs[rd_addr_a] : 32'h0);
      exp_b <= model_read(int'(rd_addr_b), cw, idx, cv,
                          (int'(rd_addr_b) < NREG) ? m_regs[rd_addr_b] : 32'h0);
      if (cw) m_regs[idx] <= cv;
      if (m_phase == 0) nxt = init_req ? 1 : 0;
      else if (m_phase == NREG + 1) nxt = 0;
      else nxt = m_phase + 1;
      m_phase  <= nxt;
      exp_busy <= (nxt != 0);
      exp_done <= (nxt == NREG + 1);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("rd_data_a", rd_data_a, exp_a);
      check("rd_data_b", rd_data_b, exp_b);
      check("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
      check("init_busy", {31'b0, init_busy}, {31'b0, exp_busy});
      check("init_done", {31'b0, init_done}, {31'b0, exp_done});
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; init_req = 1'b0;
  endtask

  initial begin
    int n_busy, n_done;
    clr = 1'b1;
    quiet();
    rd_addr_a = '0; rd_addr_b = '0;
    tick(); tick();
    check("reset_rd_a", rd_data_a, 32'h0);
    check("reset_busy", {31'b0, init_busy}, 32'h0);
    clr = 1'b0;
    tick();

    // Write then read one cycle later.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    quiet(); rd_addr_a = 4'd5;
    tick();
    check("read_after_write", rd_data_a, 32'hDEAD_BEEF);

    // Same-cycle bypass on both ports.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_1234; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
    tick();
    check("bypass_a", rd_data_a, 32'h0000_1234);
    check("bypass_b", rd_data_b, 32'h0000_1234);

    // Out-of-range write and read.
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hBAD0_BAD0; rd_addr_a = 4'd13; rd_addr_b = 4'd5;
    tick();
    check("oor_wr_err", {31'b0, wr_err}, 32'h1);
    check("oor_read", rd_data_a, 32'h0);
    check("oor_unchanged", rd_data_b, 32'hDEAD_BEEF);
    quiet();
    tick();
    check("wr_err_pulse", {31'b0, wr_err}, 32'h0);

    // Fill, then sweep; a write in the request cycle still commits.
    for (int i = 0; i < NREG; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'hA5A5_A5A5;
      tick();
    end
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 32'h1111_1111; rd_addr_b = 4'd11; init_req = 1'b1;
    tick();
    check("req_cycle_write", rd_data_b, 32'h1111_1111);
    init_req = 1'b0; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hDEAD_0002;
    n_busy = 0; n_done = 0;
    while (init_busy && n_busy < 40) begin
      n_busy++;
      if (init_done) n_done++;
      if (n_busy == 2) check("wr_during_sweep", {31'b0, wr_err}, 32'h1);
      tick();
    end
    quiet();
    check("busy_cycles", 32'(n_busy), 32'(NREG + 1));
    check("done_pulses", 32'(n_done), 32'h1);
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(NREG - 1 - i);
      tick();
      check("swept_reg", rd_data_a, (R0 && i == 0) ? 32'h0 : INIT);
    end

    // Reset during the sweep.
    rd_addr_a = 4'd4;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (5) tick();
    check("pre_clr_rd_a", rd_data_a, INIT);
    #2 clr = 1'b1;
    #1;
    check("clr_busy", {31'b0, init_busy}, 32'h0);
    check("clr_rd_a", rd_data_a, 32'h0);
    check("clr_done", {31'b0, init_done}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    rd_addr_a = 4'd9;
    repeat (3) tick();
    check("clr_no_done", {31'b0, init_done}, 32'h0);
    check("clr_regs_zero", rd_data_a, 32'h0);

    // Register 0 behaviour.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 4'd0;
    tick();
    check("r0_wr_err", {31'b0, wr_err}, 32'h0);
    quiet();
    tick();
    check("r0_read", rd_data_a, R0 ? 32'h0 : 32'hFFFF_FFFF);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if (clr) clr = 1'b0;
      else clr = ($urandom_range(0, 249) == 0);
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AW'($urandom_range(0, 15));
      init_req  = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr = 1'b0;
    quiet();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
